// File: rtl/refresh_pkg.sv
// Shared command codes, FSM state encodings and pin decode for the DRAM refresh command path.
package refresh_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    CMD_DESELECT  = 3'd0,
    CMD_NOP       = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_READ      = 3'd3,
    CMD_WRITE     = 3'd4,
    CMD_PRECHARGE = 3'd5,
    CMD_REFRESH   = 3'd6,
    CMD_MODE_REG  = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_REFRESH   = 2'd2,
    ST_PRECHARGE = 2'd3
  } state_t;

  // The reserved pattern 110 decodes as NOP; callers flag it separately.
  function automatic cmd_t decode_cmd(input logic cs, input logic ras,
                                      input logic cas, input logic we);
    cmd_t c;
    if (cs) begin
      c = CMD_DESELECT;
    end else begin
      case ({ras, cas, we})
        3'b111:  c = CMD_NOP;
        3'b011:  c = CMD_ACTIVATE;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b010:  c = CMD_PRECHARGE;
        3'b001:  c = CMD_REFRESH;
        3'b000:  c = CMD_MODE_REG;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic is_reserved(input logic cs, input logic ras,
                                       input logic cas, input logic we);
    return !cs && ({ras, cas, we} == 3'b110);
  endfunction

endpackage

// File: rtl/dram_cmd_timer.sv
// 8-bit loadable down-counter; done is high while the count is zero.
// Load takes priority over counting; the counter holds at zero.
module dram_cmd_timer
  import refresh_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/refresh_cmd_decoder.sv
// DRAM command decoder with bank/refresh FSM; all outputs registered one cycle after pin sampling, no backpressure.
// Optional REFRESH_COUNT_EN adds a 16-bit wrapping count of accepted REFRESH commands.
module refresh_cmd_decoder
  import refresh_pkg::*;
#(
  parameter int unsigned T_RFC = 8,
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RCD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  output logic [2:0]  cmd_code,
  output logic        cmd_valid,
  output logic        refresh_busy,
  output logic        refresh_done,
  output logic        bank_open,
  output logic        proto_err,
`ifdef REFRESH_COUNT_EN
  output logic [15:0] refresh_count,
`endif
  output logic        timing_err
);

  // Timer is loaded with N-1 so the state lasts N cycles ending on done.
  localparam logic [TMR_W-1:0] RFC_LD = TMR_W'(T_RFC - 1);
  localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);

  state_t           state;
  state_t           nxt_state;
  cmd_t             cmd;
  logic             rsv;
  logic             real_cmd;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             p_err;
  logic             t_err;
  logic             ref_acc;

  assign cmd      = decode_cmd(CS, RAS, CAS, WE);
  assign rsv      = is_reserved(CS, RAS, CAS, WE);
  assign real_cmd = (cmd != CMD_DESELECT) && (cmd != CMD_NOP);

  // One timer serves tRCD in ACTIVE and tRFC/tRP in the busy states;
  // those phases never overlap.
  dram_cmd_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    nxt_state = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    p_err     = rsv;
    t_err     = 1'b0;
    ref_acc   = 1'b0;
    case (state)
      ST_IDLE: begin
        case (cmd)
          CMD_REFRESH: begin
            nxt_state = ST_REFRESH;
            tmr_load  = 1'b1;
            tmr_val   = RFC_LD;
            ref_acc   = 1'b1;
          end
          CMD_ACTIVATE: begin
            nxt_state = ST_ACTIVE;
            tmr_load  = 1'b1;
            tmr_val   = RCD_LD;
          end
          CMD_READ, CMD_WRITE: p_err = 1'b1;
          default: ;
        endcase
      end
      ST_ACTIVE: begin
        case (cmd)
          CMD_PRECHARGE: begin
            nxt_state = ST_PRECHARGE;
            tmr_load  = 1'b1;
            tmr_val   = RP_LD;
          end
          CMD_REFRESH, CMD_ACTIVATE, CMD_MODE_REG: p_err = 1'b1;
          CMD_READ, CMD_WRITE: t_err = !tmr_done;
          default: ;
        endcase
      end
      default: begin
        // Busy states ignore every real command, including one in the last cycle.
        t_err = real_cmd;
        if (tmr_done) nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cmd_code     <= '0;
      cmd_valid    <= 1'b0;
      refresh_busy <= 1'b0;
      refresh_done <= 1'b0;
      bank_open    <= 1'b0;
      proto_err    <= 1'b0;
      timing_err   <= 1'b0;
`ifdef REFRESH_COUNT_EN
      refresh_count <= '0;
`endif
    end else begin
      state        <= nxt_state;
      cmd_code     <= cmd;
      cmd_valid    <= real_cmd;
      refresh_busy <= (nxt_state == ST_REFRESH);
      refresh_done <= (state == ST_REFRESH) && tmr_done;
      bank_open    <= (nxt_state == ST_ACTIVE);
      proto_err    <= p_err;
      timing_err   <= t_err;
`ifdef REFRESH_COUNT_EN
      if (ref_acc) refresh_count <= refresh_count + 16'd1;
`endif
    end
  end

`ifndef REFRESH_COUNT_EN
  logic unused_ref_acc;
  assign unused_ref_acc = ref_acc;
`endif

endmodule

// File: tb/tb_refresh_cmd_decoder.sv
// Scoreboard bench: directed command vectors push hand-computed expected outputs, a negedge monitor checks them.
module tb_refresh_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CS, RAS, CAS, WE;
  logic [2:0]  cmd_code;
  logic        cmd_valid, refresh_busy, refresh_done, bank_open, proto_err, timing_err;
`ifdef REFRESH_COUNT_EN
  logic [15:0] refresh_count;
`endif

  localparam logic [3:0] P_DES = 4'b1111, P_NOP = 4'b0111, P_ACT = 4'b0011,
                         P_RD  = 4'b0101, P_WR  = 4'b0100, P_PRE = 4'b0010,
                         P_REF = 4'b0001, P_MRS = 4'b0000, P_RSV = 4'b0110;

  // flags = {cmd_valid, refresh_busy, refresh_done, bank_open, proto_err, timing_err}
  typedef struct {
    int          tag;
    logic [2:0]  code;
    logic [5:0]  flags;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  refresh_cmd_decoder #(.T_RFC(8), .T_RP(3), .T_RCD(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CS           (CS),
    .RAS          (RAS),
    .CAS          (CAS),
    .WE           (WE),
    .cmd_code     (cmd_code),
    .cmd_valid    (cmd_valid),
    .refresh_busy (refresh_busy),
    .refresh_done (refresh_done),
    .bank_open    (bank_open),
    .proto_err    (proto_err),
`ifdef REFRESH_COUNT_EN
    .refresh_count(refresh_count),
`endif
    .timing_err   (timing_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] act;
    act = {cmd_valid, refresh_busy, refresh_done, bank_open, proto_err, timing_err};
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", exp_q[0].name, exp_q[0].tag);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      checks++;
      if (cmd_code !== exp_q[0].code || act !== exp_q[0].flags) begin
        errors++;
        $display("FAIL %s @cyc%0d: got code=%0d flags=%b, required code=%0d flags=%b",
                 exp_q[0].name, cyc, cmd_code, act, exp_q[0].code, exp_q[0].flags);
      end
      void'(exp_q.pop_front());
    end
  end

  // Drive one command for one cycle; its effect is expected in the next cycle.
  task automatic step(input logic rst, input logic [3:0] p, input logic [2:0] c,
                      input logic [5:0] f, input string nm);
    exp_t e;
    rst_n = rst;
    {CS, RAS, CAS, WE} = p;
    e.tag = cyc + 1;
    e.code = c;
    e.flags = f;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] p, input logic [2:0] c,
                     input logic [5:0] f, input string nm);
    step(1'b1, p, c, f, nm);
  endtask

  initial begin
    rst_n = 1'b0;
    {CS, RAS, CAS, WE} = P_NOP;
    @(posedge clk);
    #1;
    // reset state
    step(1'b0, P_NOP, 3'd0, 6'b000000, "rst");
    step(1'b0, P_REF, 3'd0, 6'b000000, "rst_ref");
    for (int i = 0; i < 5; i++) run(P_NOP, 3'd1, 6'b000000, "nop");

    // single refresh: busy 8 cycles, done on first idle cycle
    run(P_REF, 3'd6, 6'b110000, "ref_acc");
    for (int i = 0; i < 7; i++) run(P_NOP, 3'd1, 6'b010000, "ref_busy");
    run(P_NOP, 3'd1, 6'b001000, "ref_done");
    run(P_NOP, 3'd1, 6'b000000, "ref_idle");

    // refresh during busy, then back-to-back, then refresh in last busy cycle
    run(P_REF, 3'd6, 6'b110000, "ref2_acc");
    for (int i = 0; i < 3; i++) run(P_NOP, 3'd1, 6'b010000, "ref2_busy");
    run(P_REF, 3'd6, 6'b110001, "ref_in_busy");
    for (int i = 0; i < 3; i++) run(P_NOP, 3'd1, 6'b010000, "ref2_busy_tail");
    run(P_NOP, 3'd1, 6'b001000, "ref2_done");
    run(P_REF, 3'd6, 6'b110000, "ref_b2b");
    for (int i = 0; i < 7; i++) run(P_NOP, 3'd1, 6'b010000, "ref3_busy");
    run(P_REF, 3'd6, 6'b101001, "ref_last_cycle");
    run(P_NOP, 3'd1, 6'b000000, "ref3_idle");

    // active bank: tRCD, protocol errors, precharge of 3 cycles
    run(P_ACT, 3'd2, 6'b100100, "act");
    run(P_RD,  3'd3, 6'b100101, "rd_early");
    run(P_RD,  3'd3, 6'b100100, "rd_ok");
    run(P_WR,  3'd4, 6'b100100, "wr_ok");
    run(P_REF, 3'd6, 6'b100110, "ref_active");
    run(P_MRS, 3'd7, 6'b100110, "mrs_active");
    run(P_ACT, 3'd2, 6'b100110, "act_active");
    run(P_RSV, 3'd1, 6'b000110, "rsv_active");
    run(P_NOP, 3'd1, 6'b000100, "nop_active");
    run(P_PRE, 3'd5, 6'b100000, "pre_acc");
    run(P_NOP, 3'd1, 6'b000000, "pre_busy");
    run(P_ACT, 3'd2, 6'b100001, "act_in_pre");
    run(P_ACT, 3'd2, 6'b100001, "act_pre_last");
    run(P_ACT, 3'd2, 6'b100100, "act_after_pre");
    run(P_WR,  3'd4, 6'b100101, "wr_early");
    run(P_PRE, 3'd5, 6'b100000, "pre2_acc");
    for (int i = 0; i < 3; i++) run(P_NOP, 3'd1, 6'b000000, "pre2_busy");

    // idle-state decode
    run(P_RD,  3'd3, 6'b100010, "rd_idle");
    run(P_WR,  3'd4, 6'b100010, "wr_idle");
    run(P_PRE, 3'd5, 6'b100000, "pre_idle");
    run(P_MRS, 3'd7, 6'b100000, "mrs_idle");
    run(P_RSV, 3'd1, 6'b000010, "rsv_idle");
    run(P_DES, 3'd0, 6'b000000, "deselect");
    run(P_ACT, 3'd2, 6'b100100, "act_from_idle");
    run(P_PRE, 3'd5, 6'b100000, "pre3_acc");
    for (int i = 0; i < 3; i++) run(P_NOP, 3'd1, 6'b000000, "pre3_busy");

    // reset in the middle of a refresh aborts it without refresh_done
    run(P_REF, 3'd6, 6'b110000, "ref4_acc");
    for (int i = 0; i < 3; i++) run(P_NOP, 3'd1, 6'b010000, "ref4_busy");
    step(1'b0, P_NOP, 3'd0, 6'b000000, "rst_mid_ref");
    for (int i = 0; i < 6; i++) run(P_NOP, 3'd1, 6'b000000, "post_rst_no_done");
    run(P_RD,  3'd3, 6'b100010, "rd_after_rst");
    run(P_NOP, 3'd1, 6'b000000, "post_rst_idle");

    // two refreshes after reset
    run(P_REF, 3'd6, 6'b110000, "ref5_acc");
    for (int i = 0; i < 7; i++) run(P_NOP, 3'd1, 6'b010000, "ref5_busy");
    run(P_NOP, 3'd1, 6'b001000, "ref5_done");
    run(P_REF, 3'd6, 6'b110000, "ref6_acc");
    for (int i = 0; i < 7; i++) run(P_NOP, 3'd1, 6'b010000, "ref6_busy");
    run(P_NOP, 3'd1, 6'b001000, "ref6_done");
    run(P_NOP, 3'd1, 6'b000000, "final_idle");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

`ifdef REFRESH_COUNT_EN
    @(negedge clk);
    checks++;
    if (refresh_count !== 16'd2) begin
      errors++;
      $display("FAIL refresh_count: got %0d, required 2", refresh_count);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
